// File: rtl/sram_tp_rd_ctrl.sv
// Streams a wrapping burst from a two-port SRAM onto a valid/ready port; first beat 2+RD_LAT cycles after start.
// Requests are credit-limited by outstanding reads plus buffered words, so consumer stalls never lose data.
module sram_tp_rd_ctrl #(
  parameter int SIZE    = 64,
  parameter int DATA_WD = 32,
  parameter int RD_LAT  = 1,
  localparam int SIZE_WD   = $clog2(SIZE),
  localparam int LEN_WD    = $clog2(SIZE + 1),
  localparam int BUF_DEPTH = RD_LAT + 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [SIZE_WD-1:0] base_adr_i,
  input  logic [LEN_WD-1:0]  len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               sram_rd_val_o,
  output logic [SIZE_WD-1:0] sram_rd_adr_o,
  input  logic               sram_rd_val_i,
  input  logic [DATA_WD-1:0] sram_rd_dat_i,
  output logic               dat_val_o,
  output logic [DATA_WD-1:0] dat_o,
  input  logic               dat_rdy_i
);

  localparam int CNT_WD = $clog2(BUF_DEPTH + 1);
  localparam int PTR_WD = $clog2(BUF_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [SIZE_WD-1:0] adr_q, adr_d;
  logic [LEN_WD-1:0]  iss_rem_q, iss_rem_d;
  logic [LEN_WD-1:0]  acc_rem_q, acc_rem_d;
  logic [CNT_WD-1:0]  outst_q, outst_d;
  logic [CNT_WD-1:0]  fill_q, fill_d;
  logic [PTR_WD-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WD-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_WD-1:0] buf_q [BUF_DEPTH];
  logic [DATA_WD-1:0] buf_d [BUF_DEPTH];
  logic               done_q, done_d;

  logic issue;
  logic ret_ok;
  logic push;
  logic pop;

  // Request depends only on registered state, never on dat_rdy_i.
  assign issue  = (state_q == RUN) &&
                  (({1'b0, outst_q} + {1'b0, fill_q}) < (CNT_WD + 1)'(BUF_DEPTH));
  assign ret_ok = sram_rd_val_i && (outst_q != '0);
  assign push   = ret_ok && (fill_q != CNT_WD'(BUF_DEPTH));
  assign pop    = (fill_q != '0) && dat_rdy_i;

  assign sram_rd_val_o = issue;
  assign sram_rd_adr_o = adr_q;
  assign dat_val_o     = (fill_q != '0);
  assign dat_o         = buf_q[rd_ptr_q];
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    iss_rem_d = iss_rem_q;
    acc_rem_d = acc_rem_q;
    outst_d   = outst_q;
    fill_d    = fill_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    buf_d     = buf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d   = RUN;
            adr_d     = base_adr_i;
            iss_rem_d = len_i;
            acc_rem_d = len_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue && (iss_rem_q == LEN_WD'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (acc_rem_q == LEN_WD'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      adr_d     = (adr_q == SIZE_WD'(SIZE - 1)) ? '0 : adr_q + SIZE_WD'(1);
      iss_rem_d = iss_rem_q - LEN_WD'(1);
    end
    if (pop) acc_rem_d = acc_rem_q - LEN_WD'(1);

    case ({issue, ret_ok})
      2'b10:   outst_d = outst_q + CNT_WD'(1);
      2'b01:   outst_d = outst_q - CNT_WD'(1);
      default: outst_d = outst_q;
    endcase

    case ({push, pop})
      2'b10:   fill_d = fill_q + CNT_WD'(1);
      2'b01:   fill_d = fill_q - CNT_WD'(1);
      default: fill_d = fill_q;
    endcase

    if (push) begin
      buf_d[wr_ptr_q] = sram_rd_dat_i;
      wr_ptr_d = (wr_ptr_q == PTR_WD'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_WD'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_WD'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_WD'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      iss_rem_q <= '0;
      acc_rem_q <= '0;
      outst_q   <= '0;
      fill_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      iss_rem_q <= iss_rem_d;
      acc_rem_q <= acc_rem_d;
      outst_q   <= outst_d;
      fill_q    <= fill_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      done_q    <= done_d;
      buf_q     <= buf_d;
    end
  end

`ifdef SRAM_TP_RD_CTRL_DEBUG
  // Sticky flag: a return with nothing outstanding, or one that found the buffer full.
  logic dbg_ret_err_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dbg_ret_err_q <= 1'b0;
    else if ((sram_rd_val_i && !ret_ok) || (ret_ok && !push)) dbg_ret_err_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sram_tp_rd_ctrl.sv
// Bench for sram_tp_rd_ctrl: RD_LAT=1 and RD_LAT=2 instances, each with a behavioural SRAM,
// checked against an expected word stream mem[(base+i)%SIZE] and credit limit BUF_DEPTH.
`timescale 1ns/1ps
module tb_sram_tp_rd_ctrl;
  localparam int SIZE    = 64;
  localparam int DATA_WD = 32;
  localparam int SW      = 6;
  localparam int LW      = 7;
  localparam int LIMIT   = 400;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] start, busy, done, rd_val_o, rd_val_i, dat_val, rdy;
  logic [1:0][SW-1:0] base_adr, rd_adr;
  logic [1:0][LW-1:0] len;
  logic [1:0][DATA_WD-1:0] rd_dat, dat;
  logic [DATA_WD-1:0] mem [SIZE];

  int errors = 0;
  int checks = 0;

  int iss_adr_q[$];
  int iss_cyc_q[$];
  logic [DATA_WD-1:0] beat_q[$];
  int beat_cyc_q[$];
  int done_cnt, done_cyc, busy_cnt, busy_first, busy_last, max_infl;
  bit timed_out;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = g + 1;
    logic [LAT-1:0] vpipe = '0;
    logic [DATA_WD-1:0] dpipe [LAT];
    always @(posedge clk) begin
      vpipe[0] <= rd_val_o[g];
      dpipe[0] <= mem[rd_adr[g]];
      for (int i = 1; i < LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        dpipe[i] <= dpipe[i-1];
      end
    end
    assign rd_val_i[g] = vpipe[LAT-1];
    assign rd_dat[g]   = dpipe[LAT-1];

    sram_tp_rd_ctrl #(.SIZE(SIZE), .DATA_WD(DATA_WD), .RD_LAT(LAT)) u_dut (
      .clk(clk),
      .rstn(rstn),
      .start_i(start[g]),
      .base_adr_i(base_adr[g]),
      .len_i(len[g]),
      .busy_o(busy[g]),
      .done_o(done[g]),
      .sram_rd_val_o(rd_val_o[g]),
      .sram_rd_adr_o(rd_adr[g]),
      .sram_rd_val_i(rd_val_i[g]),
      .sram_rd_dat_i(rd_dat[g]),
      .dat_val_o(dat_val[g]),
      .dat_o(dat[g]),
      .dat_rdy_i(rdy[g])
    );
  end

  function automatic logic [DATA_WD-1:0] exp_word(input int base, input int i);
    return mem[(base + i) % SIZE];
  endfunction

  // Drives one burst on instance k and records what the DUT does each cycle (cycle 0 = start).
  task automatic run_burst(input int k, input int base, input int n, input int stall,
                           input bit rnd, input int re_cyc, input int re_base);
    iss_adr_q.delete(); iss_cyc_q.delete(); beat_q.delete(); beat_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
    max_infl = 0; timed_out = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < LIMIT; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start[k]    = (cyc == 0) || (cyc == re_cyc);
      base_adr[k] = SW'((cyc == 0) ? base : re_base);
      len[k]      = LW'((cyc == 0) ? n : (n / 2 + 1));
      rdy[k]      = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (rd_val_o[k]) begin
        iss_adr_q.push_back(int'(rd_adr[k]));
        iss_cyc_q.push_back(cyc);
      end
      if (dat_val[k] && rdy[k]) begin
        beat_q.push_back(dat[k]);
        beat_cyc_q.push_back(cyc);
      end
      if (busy[k]) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (done[k]) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (iss_adr_q.size() - beat_q.size() > max_infl) max_infl = iss_adr_q.size() - beat_q.size();
      if (done_cnt > 0 && cyc >= done_cyc + 4) begin
        timed_out = 1'b0;
        break;
      end
    end
    start[k] = 1'b0;
    rdy[k]   = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({busy[k], done[k], rd_val_o[k], rd_adr[k], dat_val[k], dat[k]} !== '0) begin
        errors++;
        $display("FAIL reset_values[%0d]: busy=%b done=%b rd_val=%b adr=%0d dat_val=%b dat=%h, required all 0",
                 k, busy[k], done[k], rd_val_o[k], rd_adr[k], dat_val[k], dat[k]);
      end
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit bad;
    run_burst(0, 5, 4, 0, 1'b0, -1, 0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL basic_timeout: no done_o within %0d cycles", LIMIT); end
    bad = (iss_adr_q.size() != 4);
    for (int i = 0; i < 4 && !bad; i++) if (iss_adr_q[i] != 5 + i || iss_cyc_q[i] != 1 + i) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL basic_issue: adr %p cycles %p, required adr 5..8 in cycles 1..4", iss_adr_q, iss_cyc_q); end
    bad = (beat_q.size() != 4);
    for (int i = 0; i < 4 && !bad; i++) if (beat_q[i] !== exp_word(5, i) || beat_cyc_q[i] != 3 + i) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL basic_data: data %p cycles %p, required 5..8 in cycles 3..6", beat_q, beat_cyc_q); end
    checks++;
    if (done_cnt != 1 || done_cyc != 7) begin
      errors++; $display("FAIL basic_done: %0d pulses last at cycle %0d, required 1 at cycle 7", done_cnt, done_cyc);
    end
    checks++;
    if (busy_cnt != 6 || busy_first != 1 || busy_last != 6) begin
      errors++; $display("FAIL basic_busy: %0d cycles from %0d to %0d, required 6 from 1 to 6", busy_cnt, busy_first, busy_last);
    end
  endtask

  task automatic test_wrap_lat2();
    bit bad;
    run_burst(1, 62, 4, 0, 1'b0, -1, 0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL wrap_timeout: no done_o within %0d cycles", LIMIT); end
    bad = (iss_adr_q.size() != 4);
    for (int i = 0; i < 4 && !bad; i++) if (iss_adr_q[i] != (62 + i) % SIZE || iss_cyc_q[i] != 1 + i) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL wrap_issue: adr %p cycles %p, required 62,63,0,1 in cycles 1..4", iss_adr_q, iss_cyc_q); end
    bad = (beat_q.size() != 4);
    for (int i = 0; i < 4 && !bad; i++) if (beat_q[i] !== exp_word(62, i) || beat_cyc_q[i] != 4 + i) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL wrap_data: data %p cycles %p, required 62,63,0,1 in cycles 4..7", beat_q, beat_cyc_q); end
    checks++;
    if (done_cnt != 1 || done_cyc != 8) begin
      errors++; $display("FAIL wrap_done: %0d pulses last at cycle %0d, required 1 at cycle 8", done_cnt, done_cyc);
    end
    checks++;
    if (busy_cnt != 7 || busy_first != 1 || busy_last != 7) begin
      errors++; $display("FAIL wrap_busy: %0d cycles from %0d to %0d, required 7 from 1 to 7", busy_cnt, busy_first, busy_last);
    end
  endtask

  task automatic test_stall();
    bit bad;
    int early;
    run_burst(0, 10, 8, 11, 1'b0, -1, 0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL stall_timeout: no done_o within %0d cycles", LIMIT); end
    early = 0;
    foreach (iss_cyc_q[i]) if (iss_cyc_q[i] < 11) early++;
    checks++;
    if (early != 3) begin errors++; $display("FAIL stall_issue_count: %0d requests during stall, required 3", early); end
    checks++;
    if (iss_cyc_q.size() < 4 || iss_cyc_q[3] != 12) begin
      errors++; $display("FAIL stall_resume: request cycles %p, required 4th request in cycle 12", iss_cyc_q);
    end
    checks++;
    if (max_infl != 3) begin errors++; $display("FAIL stall_credit: peak in-flight %0d, required 3", max_infl); end
    bad = (beat_q.size() != 8) || (iss_adr_q.size() != 8);
    for (int i = 0; i < 8 && !bad; i++) if (beat_q[i] !== exp_word(10, i) || iss_adr_q[i] != 10 + i) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL stall_data: adr %p data %p, required 10..17 in order", iss_adr_q, beat_q); end
    checks++;
    if (done_cnt != 1 || beat_cyc_q.size() == 0 || done_cyc != beat_cyc_q[$] + 1) begin
      errors++; $display("FAIL stall_done: %0d pulses at cycle %0d, beats at %p, required 1 pulse after last beat", done_cnt, done_cyc, beat_cyc_q);
    end
  endtask

  task automatic test_len_zero();
    run_burst(0, 3, 0, 0, 1'b0, -1, 0);
    checks++;
    if (timed_out || done_cnt != 1 || done_cyc != 1) begin
      errors++; $display("FAIL zero_done: %0d pulses at cycle %0d, required 1 at cycle 1", done_cnt, done_cyc);
    end
    checks++;
    if (busy_cnt != 0) begin errors++; $display("FAIL zero_busy: busy for %0d cycles, required 0", busy_cnt); end
    checks++;
    if (iss_adr_q.size() != 0 || beat_q.size() != 0) begin
      errors++; $display("FAIL zero_activity: %0d requests %0d beats, required 0 and 0", iss_adr_q.size(), beat_q.size());
    end
  endtask

  task automatic test_restart_ignored();
    bit bad;
    run_burst(0, 20, 10, 0, 1'b1, 4, 40);
    checks++;
    if (timed_out || done_cnt != 1) begin
      errors++; $display("FAIL restart_done: timeout=%0b pulses=%0d, required 0 and 1", timed_out, done_cnt);
    end
    bad = (iss_adr_q.size() != 10) || (beat_q.size() != 10);
    for (int i = 0; i < 10 && !bad; i++) if (iss_adr_q[i] != 20 + i || beat_q[i] !== exp_word(20, i)) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL restart_stream: adr %p data %p, required base 20 len 10", iss_adr_q, beat_q); end
  endtask

  task automatic test_random();
    int k, base, n, first_bad;
    bit seen [SIZE];
    for (int i = 0; i < SIZE; i++) mem[i] = $urandom;
    for (int r = 0; r < 12; r++) begin
      k    = r % 2;
      base = $urandom_range(0, SIZE - 1);
      n    = (r == 2 || r == 3) ? SIZE : $urandom_range(1, SIZE);
      run_burst(k, base, n, $urandom_range(0, 5), 1'b1, -1, 0);
      checks++;
      if (timed_out || done_cnt != 1) begin
        errors++; $display("FAIL rand%0d_done: timeout=%0b pulses=%0d, required 0 and 1", r, timed_out, done_cnt);
      end
      first_bad = -1;
      if (beat_q.size() != n || iss_adr_q.size() != n) first_bad = n;
      for (int i = 0; i < n && first_bad < 0; i++)
        if (beat_q[i] !== exp_word(base, i) || iss_adr_q[i] != (base + i) % SIZE) first_bad = i;
      checks++;
      if (first_bad >= 0) begin
        errors++; $display("FAIL rand%0d_stream: base %0d len %0d: %0d requests %0d beats, first wrong index %0d, required %0d matching words",
                           r, base, n, iss_adr_q.size(), beat_q.size(), first_bad, n);
      end
      checks++;
      if (max_infl > k + 3) begin
        errors++; $display("FAIL rand%0d_credit: peak in-flight %0d, required at most %0d", r, max_infl, k + 3);
      end
      checks++;
      if (beat_cyc_q.size() == 0 || done_cyc != beat_cyc_q[$] + 1) begin
        errors++; $display("FAIL rand%0d_done_cycle: done at %0d, required one cycle after last beat", r, done_cyc);
      end
      if (n == SIZE) begin
        foreach (seen[i]) seen[i] = 1'b0;
        foreach (iss_adr_q[i]) seen[iss_adr_q[i] % SIZE] = 1'b1;
        first_bad = -1;
        foreach (seen[i]) if (!seen[i] && first_bad < 0) first_bad = i;
        checks++;
        if (first_bad >= 0 || iss_adr_q.size() != SIZE) begin
          errors++; $display("FAIL rand%0d_full: %0d requests, address %0d missing, required every word once", r, iss_adr_q.size(), first_bad);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int stray [2];
    bit bad;
    @(negedge clk);
    start = 2'b11; base_adr[0] = SW'(20); base_adr[1] = SW'(30);
    len[0] = LW'(16); len[1] = LW'(16); rdy = 2'b11;
    @(negedge clk);
    start = 2'b00;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (!busy[k] || !rd_val_o[k]) begin
        errors++; $display("FAIL midrst_active[%0d]: busy=%b rd_val=%b before reset, required 1 and 1", k, busy[k], rd_val_o[k]);
      end
    end
    rstn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({busy[k], done[k], rd_val_o[k], rd_adr[k], dat_val[k], dat[k]} !== '0) begin
        errors++;
        $display("FAIL midrst_values[%0d]: busy=%b done=%b rd_val=%b adr=%0d dat_val=%b dat=%h, required all 0",
                 k, busy[k], done[k], rd_val_o[k], rd_adr[k], dat_val[k], dat[k]);
      end
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    stray[0] = 0; stray[1] = 0;
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (dat_val[k] || busy[k] || rd_val_o[k]) stray[k]++;
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stray[k] != 0) begin
        errors++; $display("FAIL midrst_stale[%0d]: activity in %0d cycles after release, required 0", k, stray[k]);
      end
      run_burst(k, 0, 2, 0, 1'b0, -1, 0);
      bad = timed_out || done_cnt != 1 || beat_q.size() != 2;
      if (!bad) bad = (beat_q[0] !== mem[0]) || (beat_q[1] !== mem[1]);
      checks++;
      if (bad) begin
        errors++; $display("FAIL midrst_new_burst[%0d]: data %p pulses %0d, required %h %h and 1 pulse", k, beat_q, done_cnt, mem[0], mem[1]);
      end
    end
  endtask

  initial begin
    start = '0; rdy = '1; base_adr = '0; len = '0;
    for (int i = 0; i < SIZE; i++) mem[i] = DATA_WD'(i);
    test_reset();
    test_basic();
    test_wrap_lat2();
    test_stall();
    test_len_zero();
    test_restart_ignored();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
